// File: rtl/conv_2d_coef_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Purpose  : AXI4-Lite bundle (32-bit address, 32-bit data) with master and
//            slave views. Used by conv_2d_coef_loader to reach conv_2d_csr.
// Ports    : none; signals are grouped per AXI channel (AW, W, B, AR, R).
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if;
    // Write address channel
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    // Write data channel
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    // Write response channel
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    // Read address channel
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    // Read data channel
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/conv_2d_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : conv_2d_coef_loader
// Purpose  : AXI4-Lite master that turns each accepted (index, value)
//            coefficient into four CSR writes on conv_2d_csr:
//            COEF_NUM, COEF_VAL, WR_STB=1, WR_STB=0.
// Ports    : clk_i, rst_n_i (async, active-low)
//            coef_valid_i / coef_ready_o / coef_num_i / coef_val_i : input
//              coefficient handshake
//            busy_o    : write sequence in progress
//            err_o     : sticky, set by any non-OKAY write response
//            err_clr_i : synchronous clear of err_o (a new error wins)
//            csr_o     : AXI4-Lite master port (read channel tied off)
// Revision : 1.0 - initial release
// ============================================================================
module conv_2d_coef_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        coef_valid_i,
    output logic        coef_ready_o,
    input  logic [5:0]  coef_num_i,
    input  logic [15:0] coef_val_i,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i,
    axi4_lite_if.master csr_o
);

    // conv_2d_csr register indices (word offsets from BASE_ADDR)
    localparam logic [1:0] c_WR_STB_CR   = 2'd0;
    localparam logic [1:0] c_COEF_NUM_CR = 2'd1;
    localparam logic [1:0] c_COEF_VAL_CR = 2'd2;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ADDR_DATA = 2'd1;
    localparam logic [1:0] c_ST_WAIT_B    = 2'd2;

    localparam logic [1:0] c_STEP_LAST = 2'd3;

    logic [1:0]  r_state,   w_state_nxt;
    logic [1:0]  r_step,    w_step_nxt;
    logic [5:0]  r_num,     w_num_nxt;
    logic [15:0] r_val,     w_val_nxt;
    logic        r_awvalid, w_awvalid_nxt;
    logic        r_wvalid,  w_wvalid_nxt;
    logic [31:0] r_awaddr,  w_awaddr_nxt;
    logic [31:0] r_wdata,   w_wdata_nxt;
    logic [3:0]  r_wstrb,   w_wstrb_nxt;
    logic        r_err,     w_err_nxt;

    logic        w_launch;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_err;

    // Payload of the write about to be launched: step 0 out of IDLE using the
    // live inputs, otherwise the step following the one just completed.
    logic [1:0]  w_ld_step;
    logic [5:0]  w_ld_num;
    logic [15:0] w_ld_val;
    logic [1:0]  w_ld_reg;
    logic [31:0] w_ld_addr;
    logic [31:0] w_ld_data;
    logic [3:0]  w_ld_strb;

    assign w_ld_step = (r_state == c_ST_IDLE) ? 2'd0 : (r_step + 2'd1);
    assign w_ld_num  = (r_state == c_ST_IDLE) ? coef_num_i : r_num;
    assign w_ld_val  = (r_state == c_ST_IDLE) ? coef_val_i : r_val;

    always_comb begin
        w_ld_reg  = c_WR_STB_CR;
        w_ld_data = 32'd0;
        w_ld_strb = 4'b0001;
        case (w_ld_step)
            2'd0: begin
                w_ld_reg  = c_COEF_NUM_CR;
                w_ld_data = {26'd0, w_ld_num};
            end
            2'd1: begin
                w_ld_reg  = c_COEF_VAL_CR;
                w_ld_data = {16'd0, w_ld_val};
                w_ld_strb = 4'b0011;
            end
            2'd2:    w_ld_data = 32'd1;
            default: w_ld_data = 32'd0;
        endcase
    end

    assign w_ld_addr = BASE_ADDR + {28'd0, w_ld_reg, 2'b00};

    assign w_aw_hs = r_awvalid && csr_o.awready;
    assign w_w_hs  = r_wvalid  && csr_o.wready;
    assign w_b_err = (r_state == c_ST_WAIT_B) && csr_o.bvalid && (csr_o.bresp != 2'b00);

    // Next-state logic. AW and W are launched together and retired
    // independently; WAIT_B is entered only once both have handshaken, which
    // keeps exactly one write outstanding.
    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_num_nxt     = r_num;
        w_val_nxt     = r_val;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_launch      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (coef_valid_i) begin
                    w_num_nxt   = coef_num_i;
                    w_val_nxt   = coef_val_i;
                    w_step_nxt  = 2'd0;
                    w_launch    = 1'b1;
                    w_state_nxt = c_ST_ADDR_DATA;
                end
            end
            c_ST_ADDR_DATA: begin
                if (w_aw_hs) w_awvalid_nxt = 1'b0;
                if (w_w_hs)  w_wvalid_nxt  = 1'b0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) w_state_nxt = c_ST_WAIT_B;
            end
            c_ST_WAIT_B: begin
                if (csr_o.bvalid) begin
                    if (r_step == c_STEP_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_step_nxt  = r_step + 2'd1;
                        w_launch    = 1'b1;
                        w_state_nxt = c_ST_ADDR_DATA;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase

        if (w_launch) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_awaddr_nxt  = w_ld_addr;
            w_wdata_nxt   = w_ld_data;
            w_wstrb_nxt   = w_ld_strb;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    assign w_err_nxt = w_b_err | (r_err & ~err_clr_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= c_ST_IDLE;
            r_step    <= 2'd0;
            r_num     <= 6'd0;
            r_val     <= 16'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_num     <= w_num_nxt;
            r_val     <= w_val_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign coef_ready_o = (r_state == c_ST_IDLE);
    assign busy_o       = (r_state != c_ST_IDLE);
    assign err_o        = r_err;

    assign csr_o.awvalid = r_awvalid;
    assign csr_o.awaddr  = r_awaddr;
    assign csr_o.awprot  = 3'd0;
    assign csr_o.wvalid  = r_wvalid;
    assign csr_o.wdata   = r_wdata;
    assign csr_o.wstrb   = r_wstrb;
    assign csr_o.bready  = (r_state == c_ST_WAIT_B);

    // Write-only master: the read channel is permanently idle.
    assign csr_o.arvalid = 1'b0;
    assign csr_o.araddr  = 32'd0;
    assign csr_o.arprot  = 3'd0;
    assign csr_o.rready  = 1'b1;

    logic w_unused_rd;
    assign w_unused_rd = &{1'b0, csr_o.arready, csr_o.rvalid, csr_o.rdata, csr_o.rresp};

endmodule
`default_nettype wire

// File: tb/tb_conv_2d_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_2d_coef_loader
// Purpose  : Self-checking bench for conv_2d_coef_loader. An AXI4-Lite slave
//            with programmable AW/W/B delays stands in for conv_2d_csr and
//            keeps a small model of its COEF_NUM/COEF_VAL/WR_STB registers.
//            Expected writes are queued at coefficient accept and compared
//            as the slave commits each write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_2d_coef_loader;

    localparam logic [31:0] c_BASE = 32'h4000_0000;

    logic        clk;
    logic        rst_n;
    logic        coef_valid;
    logic        coef_ready;
    logic [5:0]  coef_num;
    logic [15:0] coef_val;
    logic        busy;
    logic        err;
    logic        err_clr;

    axi4_lite_if axi ();

    conv_2d_coef_loader #(.BASE_ADDR(c_BASE)) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .coef_valid_i (coef_valid),
        .coef_ready_o (coef_ready),
        .coef_num_i   (coef_num),
        .coef_val_i   (coef_val),
        .busy_o       (busy),
        .err_o        (err),
        .err_clr_i    (err_clr),
        .csr_o        (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {awaddr, wdata, wstrb} for one step of the sequence.
    function automatic logic [67:0] f_exp(input int step, input logic [5:0] n, input logic [15:0] v);
        case (step)
            0:       return {c_BASE + 32'h4, 26'd0, n, 4'b0001};
            1:       return {c_BASE + 32'h8, 16'd0, v, 4'b0011};
            2:       return {c_BASE,         32'd1,    4'b0001};
            default: return {c_BASE,         32'd0,    4'b0001};
        endcase
    endfunction

    // ---------------- slave / conv_2d_csr model ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_delay  = 0;
    logic        err_mode = 1'b0;

    logic        s_got_aw, s_got_w, s_bvalid;
    logic [1:0]  s_bresp;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    int          s_aw_cnt, s_w_cnt, s_b_cnt;

    int          wr_total   = 0;
    int          stb_pulses = 0;
    logic [5:0]  m_num   = '0;
    logic [15:0] m_val   = '0;
    logic [5:0]  stb_num = '0;
    logic [15:0] stb_val = '0;

    logic [67:0] got_q[$];
    logic [67:0] exp_q[$];

    assign axi.awready = axi.awvalid && !s_got_aw && (s_aw_cnt >= aw_delay);
    assign axi.wready  = axi.wvalid  && !s_got_w  && (s_w_cnt  >= w_delay);
    assign axi.bvalid  = s_bvalid;
    assign axi.bresp   = s_bresp;
    assign axi.arready = 1'b0;
    assign axi.rvalid  = 1'b0;
    assign axi.rdata   = 32'd0;
    assign axi.rresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_got_aw <= 1'b0; s_got_w <= 1'b0; s_bvalid <= 1'b0; s_bresp <= 2'b00;
            s_awaddr <= '0;   s_wdata <= '0;   s_wstrb  <= '0;
            s_aw_cnt <= 0;    s_w_cnt <= 0;    s_b_cnt  <= 0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                s_got_aw <= 1'b1; s_awaddr <= axi.awaddr; s_aw_cnt <= 0;
            end else if (axi.awvalid && !s_got_aw) begin
                s_aw_cnt <= s_aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                s_got_w <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; s_w_cnt <= 0;
            end else if (axi.wvalid && !s_got_w) begin
                s_w_cnt <= s_w_cnt + 1;
            end
            if (s_got_aw && s_got_w && !s_bvalid) begin
                if (s_b_cnt >= b_delay) begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= (err_mode && s_awaddr == c_BASE + 32'h8) ? 2'b10 : 2'b00;
                    s_got_aw <= 1'b0;
                    s_got_w  <= 1'b0;
                    s_b_cnt  <= 0;
                    got_q.push_back({s_awaddr, s_wdata, s_wstrb});
                    wr_total <= wr_total + 1;
                    if (s_awaddr == c_BASE + 32'h4) m_num <= s_wdata[5:0];
                    else if (s_awaddr == c_BASE + 32'h8) m_val <= s_wdata[15:0];
                    else if (s_awaddr == c_BASE && s_wdata[0]) begin
                        stb_pulses <= stb_pulses + 1;
                        stb_num    <= m_num;
                        stb_val    <= m_val;
                    end
                end else begin
                    s_b_cnt <= s_b_cnt + 1;
                end
            end
            if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
        end
    end

    // ---------------- monitors (sampled on the falling edge) ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          viol = 0;
    int          aw_hi = 0, w_hi = 0, b_seen = 0;
    int          acc_cnt = 0, acc_cyc = 0;
    logic        stream_on = 1'b0;
    int          ready_log[$];
    logic        p_aw_stall = 1'b0, p_w_stall = 1'b0;
    logic [31:0] p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    logic [67:0] mon_obs;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((axi.awvalid || axi.wvalid) && s_bvalid) viol++;
            if (axi.awvalid && s_got_aw) viol++;
            if (axi.wvalid && s_got_w) viol++;
            if (p_aw_stall && (!axi.awvalid || axi.awaddr != p_awaddr)) viol++;
            if (p_w_stall && (!axi.wvalid || axi.wdata != p_wdata || axi.wstrb != p_wstrb)) viol++;
            p_aw_stall = axi.awvalid && !axi.awready;
            p_w_stall  = axi.wvalid && !axi.wready;
            p_awaddr   = axi.awaddr;
            p_wdata    = axi.wdata;
            p_wstrb    = axi.wstrb;
            if (axi.awvalid) aw_hi++;
            if (axi.wvalid) w_hi++;
            if (axi.bvalid && axi.bready) b_seen++;
            if (stream_on && coef_ready) ready_log.push_back(cyc);
            if (coef_valid && coef_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
                for (int s = 0; s < 4; s++) exp_q.push_back(f_exp(s, coef_num, coef_val));
            end
        end else begin
            p_aw_stall = 1'b0;
            p_w_stall  = 1'b0;
        end
        while (got_q.size() > 0) begin
            mon_obs = got_q.pop_front();
            if (exp_q.size() == 0) chk("write_unexpected", mon_obs, 68'd0);
            else chk("write", mon_obs, exp_q.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one coefficient and returns the cycle after it is accepted, with
    // the inputs scrambled to show they are not sampled again.
    task automatic send(input logic [5:0] n, input logic [15:0] v);
        int a0 = acc_cnt;
        int k  = 0;
        coef_num   = n;
        coef_val   = v;
        coef_valid = 1'b1;
        while (acc_cnt == a0 && k < 200) begin tick(); k++; end
        if (acc_cnt == a0) chk("accept_timeout", 68'(k), 68'd0);
        coef_valid = 1'b0;
        coef_num   = 6'($urandom);
        coef_val   = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || s_bvalid || exp_q.size() != 0) && k < 500) begin tick(); k++; end
        chk({tag, "_idle_timeout"}, 68'(k >= 500), 68'd0);
    endtask

    task automatic wait_b_err();
        int k = 0;
        while (!(axi.bvalid && axi.bready && axi.bresp != 2'b00) && k < 100) begin tick(); k++; end
        chk("b_err_wait_timeout", 68'(k >= 100), 68'd0);
    endtask

    logic [5:0]  st_num[4] = '{6'h3F, 6'h00, 6'h15, 6'h2A};
    logic [15:0] st_val[4] = '{16'hFFFF, 16'h0000, 16'h5A5A, 16'h8001};

    initial begin
        int k;
        int base;
        int a0;
        rst_n      = 1'b0;
        coef_valid = 1'b0;
        coef_num   = '0;
        coef_val   = '0;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_awvalid", 68'(axi.awvalid), 68'd0);
        chk("rst_wvalid",  68'(axi.wvalid),  68'd0);
        chk("rst_bready",  68'(axi.bready),  68'd0);
        chk("rst_awaddr",  68'(axi.awaddr),  68'd0);
        chk("rst_wdata",   68'(axi.wdata),   68'd0);
        chk("rst_wstrb",   68'(axi.wstrb),   68'd0);
        chk("rst_ready",   68'(coef_ready),  68'd1);
        chk("rst_busy",    68'(busy),        68'd0);
        chk("rst_err",     68'(err),         68'd0);

        // Single coefficient, zero-wait slave
        send(6'd5, 16'hABCD);
        k = 0;
        while (!coef_ready && k < 100) begin tick(); k++; end
        chk("single_ready_latency", 68'(cyc - acc_cyc), 68'd13);
        wait_idle("single");
        chk("single_stb_pulses", 68'(stb_pulses), 68'd1);
        chk("single_stb_num",    68'(stb_num),    68'd5);
        chk("single_stb_val",    68'(stb_val),    68'hABCD);

        // Skewed handshakes: AW late
        aw_delay = 3; w_delay = 0;
        aw_hi = 0; w_hi = 0; b_seen = 0; base = wr_total;
        send(6'h2A, 16'h1234);
        wait_idle("skew_aw");
        chk("skew_aw_awvalid_cycles", 68'(aw_hi), 68'd16);
        chk("skew_aw_wvalid_cycles",  68'(w_hi),  68'd4);
        chk("skew_aw_b_count",        68'(b_seen), 68'd4);
        chk("skew_aw_writes",         68'(wr_total - base), 68'd4);

        // Skewed handshakes: W late
        aw_delay = 0; w_delay = 3;
        aw_hi = 0; w_hi = 0; b_seen = 0;
        send(6'h11, 16'hC0DE);
        wait_idle("skew_w");
        chk("skew_w_awvalid_cycles", 68'(aw_hi), 68'd4);
        chk("skew_w_wvalid_cycles",  68'(w_hi),  68'd16);
        chk("skew_w_b_count",        68'(b_seen), 68'd4);
        w_delay = 0;

        // Back-to-back stream with valid held high
        ready_log.delete();
        base      = wr_total;
        a0        = acc_cnt;
        stream_on = 1'b1;
        coef_num  = st_num[0];
        coef_val  = st_val[0];
        coef_valid = 1'b1;
        k = 0;
        while (acc_cnt < a0 + 4 && k < 300) begin
            tick();
            k++;
            if (acc_cnt - a0 < 4) begin
                coef_num = st_num[acc_cnt - a0];
                coef_val = st_val[acc_cnt - a0];
            end
        end
        coef_valid = 1'b0;
        stream_on  = 1'b0;
        wait_idle("stream");
        chk("stream_writes",       68'(wr_total - base),   68'd16);
        chk("stream_ready_cycles", 68'(ready_log.size()),  68'd4);
        for (int i = 1; i < 4; i++) begin
            if (ready_log.size() > i)
                chk("stream_ready_spacing", 68'(ready_log[i] - ready_log[i-1]), 68'd13);
        end
        chk("stream_protocol_violations", 68'(viol), 68'd0);

        // Error response on the COEF_VAL write
        err_mode = 1'b1;
        base = wr_total;
        send(6'd7, 16'h0F0F);
        wait_b_err();
        chk("err_before_b", 68'(err), 68'd0);
        tick();
        chk("err_after_b", 68'(err), 68'd1);
        wait_idle("err");
        chk("err_all_steps_issued", 68'(wr_total - base), 68'd4);
        chk("err_sticky", 68'(err), 68'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 68'(err), 68'd0);

        // Clear coincident with a new error: set wins
        send(6'd8, 16'h00F0);
        wait_b_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_set_wins", 68'(err), 68'd1);
        wait_idle("err2");
        err_mode = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr  = 1'b0;

        // Reset while step 2 AW is pending
        base = wr_total;
        send(6'd3, 16'h7777);
        k = 0;
        while (!(axi.awvalid && wr_total == base + 2) && k < 100) begin tick(); k++; end
        chk("rst_mid_reach_step2", 68'(k >= 100), 68'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_awvalid", 68'(axi.awvalid), 68'd0);
        chk("rst_mid_wvalid",  68'(axi.wvalid),  68'd0);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_mid_busy",  68'(busy),       68'd0);
        chk("rst_mid_ready", 68'(coef_ready), 68'd1);
        base = wr_total;
        k    = stb_pulses;
        send(6'd9, 16'h1357);
        wait_idle("after_rst");
        chk("after_rst_writes", 68'(wr_total - base), 68'd4);
        chk("after_rst_stb",    68'(stb_pulses - k),  68'd1);
        chk("after_rst_stb_num", 68'(stb_num), 68'd9);

        // Slow B: loader must wait with bready high and nothing new issued
        b_delay = 20;
        send(6'd12, 16'hBEEF);
        k = 0;
        while (!(s_got_aw && s_got_w) && k < 100) begin tick(); k++; end
        chk("bstall_pending", 68'(k >= 100), 68'd0);
        a0 = 1;
        for (int i = 0; i < 20; i++) begin
            if (!(axi.bready && busy && !axi.awvalid && !axi.wvalid)) a0 = 0;
            tick();
        end
        chk("bstall_hold", 68'(a0), 68'd1);
        wait_idle("bstall");
        b_delay = 0;
        chk("bstall_stb_val", 68'(stb_val), 68'hBEEF);

        chk("final_protocol_violations", 68'(viol), 68'd0);
        chk("final_queue_empty", 68'(exp_q.size()), 68'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
